regfile_mp_pc: RTL

//  Parametrised multi-port CPU register file, successor to the fixed 2R/2W file.
//  - Configurable width, depth and read/write port counts.
//  - Dedicated PC / LR / SP / ST registers with side-band update paths:
//    PC increment/load, call link, SP push/pop, status write.
//  - Deterministic write priority, plus a registered write-conflict flag.
//  - Sits between decode (read ports) and writeback (write ports) in the CPU32 core.

---
 rtl/regfile_pkg.sv | 63 ++++++
 rtl/regfile_wr_arb.sv | 65 ++++++
 rtl/regfile_mp_pc.sv | 110 +++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and helpers for the regfile_mp_pc register file.
//   sp_op_t       stack-pointer side-band opcode
//   *_IDX_DEF     default indices of the dedicated PC/SP/LR/ST registers
//   src_t         next-value source selected for one register
//   next_special  priority chain deciding which source updates a register
package regfile_pkg;

  typedef enum logic [1:0] {
    SP_NONE = 2'b00,
    SP_PUSH = 2'b01,
    SP_POP  = 2'b10
  } sp_op_t;

  localparam int PC_IDX_DEF = 31;
  localparam int SP_IDX_DEF = 30;
  localparam int LR_IDX_DEF = 29;
  localparam int ST_IDX_DEF = 28;

  typedef enum logic [2:0] {
    SRC_HOLD,
    SRC_GEN,
    SRC_PC_IN,
    SRC_PC_INC,
    SRC_SP_DEC,
    SRC_SP_INC,
    SRC_ST_IN
  } src_t;

  // Decides which source drives a register's next value. Width independent,
  // so the same chain serves the storage update and the read forwarding path.
  function automatic src_t next_special(
    input logic       is_pc,
    input logic       is_lr,
    input logic       is_sp,
    input logic       is_st,
    input logic       gen_we,
    input logic       pc_load,
    input logic       pc_incr,
    input logic       lr_save,
    input logic [1:0] sp_op,
    input logic       st_wr
  );
    src_t src;
    src = gen_we ? SRC_GEN : SRC_HOLD;
    if (is_pc) begin
      if (pc_load)                src = SRC_PC_IN;
      else if (!gen_we && pc_incr) src = SRC_PC_INC;
    end else if (is_lr) begin
      // LR takes old PC+1 on a call; lr_save alone does nothing
      if (lr_save && pc_load) src = SRC_PC_INC;
    end else if (is_sp) begin
      // a general write to SP swallows any push/pop that cycle
      if (!gen_we) begin
        if (sp_op == SP_PUSH)     src = SRC_SP_DEC;
        else if (sp_op == SP_POP) src = SRC_SP_INC;
      end
    end else if (is_st) begin
      if (st_wr) src = SRC_ST_IN;
    end
    return src;
  endfunction

endpackage

// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb: next-value / enable select for one register (index IDX).
//   we, wa, wd            general write ports (highest enabled port wins)
//   cur                   this register's stored value
//   pc_cur                stored PC, source of PC+1 for PC and LR
//   pc_load, pc_in        branch load
//   pc_incr, lr_save      PC increment, call link
//   sp_op, st_wr, st_in   stack adjust, status write
//   en, nxt               update strobe and value for the next edge
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int NWR    = 2,
  parameter int IDX    = 0,
  parameter int PC_IDX = PC_IDX_DEF,
  parameter int SP_IDX = SP_IDX_DEF,
  parameter int LR_IDX = LR_IDX_DEF,
  parameter int ST_IDX = ST_IDX_DEF
) (
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] wa,
  input  logic [NWR*DW-1:0] wd,
  input  logic [DW-1:0]     cur,
  input  logic [DW-1:0]     pc_cur,
  input  logic              pc_load,
  input  logic [DW-1:0]     pc_in,
  input  logic              pc_incr,
  input  logic              lr_save,
  input  logic [1:0]        sp_op,
  input  logic              st_wr,
  input  logic [DW-1:0]     st_in,
  output logic              en,
  output logic [DW-1:0]     nxt
);

  logic          gen_we;
  logic [DW-1:0] gen_wd;
  src_t          src;

  always_comb begin
    gen_we = 1'b0;
    gen_wd = '0;
    // ascending scan: the last match, i.e. the highest port, wins
    for (int p = 0; p < NWR; p++) begin
      if (we[p] && (wa[p*AW +: AW] == AW'(IDX))) begin
        gen_we = 1'b1;
        gen_wd = wd[p*DW +: DW];
      end
    end
    src = next_special(IDX == PC_IDX, IDX == LR_IDX, IDX == SP_IDX, IDX == ST_IDX,
                       gen_we, pc_load, pc_incr, lr_save, sp_op, st_wr);
    en = (src != SRC_HOLD);
    case (src)
      SRC_GEN:    nxt = gen_wd;
      SRC_PC_IN:  nxt = pc_in;
      SRC_PC_INC: nxt = pc_cur + DW'(1);
      SRC_SP_DEC: nxt = cur - DW'(1);
      SRC_SP_INC: nxt = cur + DW'(1);
      SRC_ST_IN:  nxt = st_in;
      default:    nxt = cur;
    endcase
  end

endmodule

// File: rtl/regfile_mp_pc.sv
// regfile_mp_pc: parametrised multi-port register file with PC/LR/SP/ST side-band.
//   clk, rst            clock, synchronous active-high reset
//   ra / rd             NRD combinational read ports (out-of-range address reads 0)
//   we / wa / wd        NWR write ports, highest port wins on a collision
//   pc_incr, pc_load, pc_in, lr_save, sp_op, st_wr, st_in   side-band updates
//   pc_out, lr_out, sp_out, st_out                          registered contents
//   wr_conflict         registered pulse: two enabled ports hit the same valid address
// Build option: define REGFILE_BYPASS_EN to forward this cycle's write value to rd.
module regfile_mp_pc
  import regfile_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int PC_IDX = PC_IDX_DEF,
  parameter int SP_IDX = SP_IDX_DEF,
  parameter int LR_IDX = LR_IDX_DEF,
  parameter int ST_IDX = ST_IDX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*DW-1:0] rd,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] wa,
  input  logic [NWR*DW-1:0] wd,
  input  logic              pc_incr,
  input  logic              pc_load,
  input  logic [DW-1:0]     pc_in,
  input  logic              lr_save,
  input  logic [1:0]        sp_op,
  input  logic              st_wr,
  input  logic [DW-1:0]     st_in,
  output logic [DW-1:0]     pc_out,
  output logic [DW-1:0]     lr_out,
  output logic [DW-1:0]     sp_out,
  output logic [DW-1:0]     st_out,
  output logic              wr_conflict
);

  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [DW-1:0]    regs  [NREGS];
  logic [DW-1:0]    nxt_v [NREGS];
  logic [NREGS-1:0] en_v;
  logic             conflict;

  for (genvar i = 0; i < NREGS; i++) begin : g_arb
    regfile_wr_arb #(
      .DW(DW), .AW(AW), .NWR(NWR), .IDX(i),
      .PC_IDX(PC_IDX), .SP_IDX(SP_IDX), .LR_IDX(LR_IDX), .ST_IDX(ST_IDX)
    ) u_arb (
      .we(we), .wa(wa), .wd(wd),
      .cur(regs[i]), .pc_cur(regs[PC_IDX]),
      .pc_load(pc_load), .pc_in(pc_in), .pc_incr(pc_incr),
      .lr_save(lr_save), .sp_op(sp_op),
      .st_wr(st_wr), .st_in(st_in),
      .en(en_v[i]), .nxt(nxt_v[i])
    );
  end

  // out-of-range addresses can never collide, so they are excluded here
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < NWR; i++) begin
      for (int j = i + 1; j < NWR; j++) begin
        if (we[i] && we[j] && (wa[i*AW +: AW] == wa[j*AW +: AW]) &&
            (int'(wa[i*AW +: AW]) < NREGS))
          conflict = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      wr_conflict <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (en_v[i]) regs[i] <= nxt_v[i];
      end
      wr_conflict <= conflict;
    end
  end

  always_comb begin
    logic [AW-1:0] addr;
    logic [IW-1:0] idx;
    rd = '0;
    for (int k = 0; k < NRD; k++) begin
      addr = ra[k*AW +: AW];
      idx  = IW'(addr);
      if (int'(addr) < NREGS) begin
`ifdef REGFILE_BYPASS_EN
        rd[k*DW +: DW] = en_v[idx] ? nxt_v[idx] : regs[idx];
`else
        rd[k*DW +: DW] = regs[idx];
`endif
      end
    end
  end

  assign pc_out = regs[PC_IDX];
  assign lr_out = regs[LR_IDX];
  assign sp_out = regs[SP_IDX];
  assign st_out = regs[ST_IDX];

endmodule
